// File: rtl/rf_dump_reader.sv
// rf_dump_reader: waits for the CPU PC to hit a trigger address (or for an
// armed-cycle timeout), freezes the CPU, then walks the debug port over all
// 32 registers. The result goes out as one 33-word frame on a valid/ready
// stream: the captured PC first, then r0..r31.
module rf_dump_reader #(
  parameter logic [31:0] TRIG_PC    = 32'h0000_0048,
  parameter int          MAX_CYCLES = 1000,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arm,
  input  logic [31:0] pc,
  output logic        cpu_hold,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HEADER,
    S_SEL,
    S_SEND,
    S_DONE
  } state_t;

  // The trigger fires when the counter reaches this value, so the counter
  // never goes past it and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [4:0]       LAST_REG = 5'd31;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Capture FSM. reg_sel doubles as the register index being walked. The
  // captured PC is placed directly into out_data, which is the header word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cpu_hold  <= 1'b0;
      reg_sel   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state    <= S_ARMED;
            cnt      <= '0;
            timeout  <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_ARMED: begin
          // A PC match takes priority over a timeout on the same edge. The
          // instruction at the trigger PC commits on this edge, and the hold
          // takes effect from the next cycle.
          if (pc == TRIG_PC) begin
            out_data  <= pc;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            timeout   <= 1'b0;
            cpu_hold  <= 1'b1;
            state     <= S_HEADER;
          end else if (cnt == CNT_LAST) begin
            out_data  <= pc;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            timeout   <= 1'b1;
            cpu_hold  <= 1'b1;
            state     <= S_HEADER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HEADER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            reg_sel   <= '0;
            state     <= S_SEL;
          end
        end
        S_SEL: begin
          // One settle cycle so that reg_data reflects the new reg_sel.
          // r0 is architecturally zero, so it is forced here.
          out_data  <= (reg_sel == 5'd0) ? 32'd0 : reg_data;
          out_last  <= (reg_sel == LAST_REG);
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (reg_sel != LAST_REG) begin
              reg_sel <= reg_sel + 5'd1;
              state   <= S_SEL;
            end else begin
              // The CPU stays frozen until the next arm.
              out_last <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
